rf_dump: RTL and testbench

Register-file dump engine that acts as the read-side initiator on a 16x16 triple-ported register file. On a start pulse it walks a contiguous address range through one read port (`rd_addr`/`rd_en`/`rd_data`). It captures each 16-bit value and streams it out with its address over a valid/ready interface. The output feeds a debug or UART transmit path. It sits beside the register file and shares a read port with the pipeline; arbitration of that port is external.

---
 rtl/rf_dump.sv | 109 ++++++++++
 tb/tb_rf_dump.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/rf_dump.sv
// Register-file dump engine: walks START_ADDR..END_ADDR through one read port
// and streams (address, data) pairs out over a valid/ready interface.
module rf_dump #(
  localparam int unsigned ADDR_W = 4,
  localparam int unsigned DATA_W = 16,
  parameter logic [ADDR_W-1:0] START_ADDR = 4'h0,
  parameter logic [ADDR_W-1:0] END_ADDR   = 4'hF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_SEND = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_nxt;
  logic              capture;

  // Next-state and address counter; abort outranks capture and handshake.
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    capture   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_READ;
          addr_nxt  = START_ADDR;
        end
      end
      S_READ: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_SEND;
          capture   = 1'b1;
        end
      end
      S_SEND: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (out_ready) begin
          if (addr == END_ADDR) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_READ;
            if (addr < END_ADDR) begin
              addr_nxt = addr + ADDR_W'(1);
            end
          end
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State register plus outputs decoded from the next state, so every output is a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      addr      <= START_ADDR;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
    end else begin
      state     <= state_nxt;
      addr      <= addr_nxt;
      busy      <= (state_nxt != S_IDLE);
      done      <= (state_nxt == S_DONE);
      rd_en     <= (state_nxt == S_READ);
      out_valid <= (state_nxt == S_SEND);
      if (state_nxt == S_READ) begin
        rd_addr <= addr_nxt;
      end
      if (capture) begin
        out_data <= rd_data;
        out_addr <= addr;
      end
    end
  end

endmodule

// File: tb/tb_rf_dump.sv
// Directed bench for rf_dump: full range, backpressure, ignored start, abort,
// mid-dump reset, and a 3..5 sub-range instance.
module tb_rf_dump;

  logic        clk = 1'b0;
  logic        rst;
  logic        start0, abort0, ready0;
  logic        busy0, done0, rd_en0, valid0;
  logic [3:0]  rd_addr0, out_addr0;
  logic [15:0] rd_data0, out_data0;
  logic        start1, abort1, ready1;
  logic        busy1, done1, rd_en1, valid1;
  logic [3:0]  rd_addr1, out_addr1;
  logic [15:0] rd_data1, out_data1;

  logic [15:0] rf0 [16];
  logic [15:0] rf1 [16];

  always #5 clk = ~clk;

  assign rd_data0 = rf0[rd_addr0];
  assign rd_data1 = rf1[rd_addr1];

  rf_dump u_full (
    .clk(clk), .rst(rst), .start(start0), .abort(abort0),
    .busy(busy0), .done(done0), .rd_addr(rd_addr0), .rd_en(rd_en0),
    .rd_data(rd_data0), .out_addr(out_addr0), .out_data(out_data0),
    .out_valid(valid0), .out_ready(ready0)
  );

  rf_dump #(.START_ADDR(4'h3), .END_ADDR(4'h5)) u_sub (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1),
    .busy(busy1), .done(done1), .rd_addr(rd_addr1), .rd_en(rd_en1),
    .rd_data(rd_data1), .out_addr(out_addr1), .out_data(out_data1),
    .out_valid(valid1), .out_ready(ready1)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  int   words, done_cnt, done_cyc, rden_cnt, order_err, stab_err, first_valid;
  logic busy_after;

  // Drives u_full for ncyc cycles after start was sampled.
  // mode 0: ready=1; mode 1: ready 1-0-0-1; mode 2: ready=1 with start pulses while busy.
  task automatic run0(input int mode, input int ncyc);
    logic        r;
    logic        have_hold;
    logic [3:0]  hold_a;
    logic [15:0] hold_d;
    logic        pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    words = 0; done_cnt = 0; done_cyc = -1; rden_cnt = 0;
    order_err = 0; stab_err = 0; first_valid = -1; busy_after = 1'b1;
    have_hold = 1'b0; hold_a = '0; hold_d = '0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      start0 = (mode == 2) && (c == 5 || c == 20 || c == 33);
      if (rd_en0) rden_cnt++;
      if (done0) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (c == done_cyc + 1) busy_after = busy0;
      if (valid0 && first_valid < 0) first_valid = c;
      if (have_hold && valid0 && (out_addr0 != hold_a || out_data0 != hold_d)) stab_err++;
      r = (mode == 1) ? pat[c % 4] : 1'b1;
      ready0 = r;
      if (valid0 && r) begin
        if (out_addr0 != 4'(words) || out_data0 != 16'(16'h1000 + words)) order_err++;
        words++;
        have_hold = 1'b0;
      end else if (valid0) begin
        have_hold = 1'b1;
        hold_a = out_addr0;
        hold_d = out_data0;
      end
    end
  endtask

  initial begin
    int          found, dcnt, n1, range_err;
    logic [3:0]  a1 [3];
    logic [15:0] d1 [3];
    rst = 1'b1;
    start0 = 1'b0; abort0 = 1'b0; ready0 = 1'b0;
    start1 = 1'b0; abort1 = 1'b0; ready1 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rf0[i] = 16'(16'h1000 + i);
      rf1[i] = 16'h0;
    end
    rf1[3] = 16'hAAAA;
    rf1[4] = 16'h5555;
    rf1[5] = 16'hBEEF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", busy0, 0);
    check("reset_valid", valid0, 0);
    check("reset_rd_addr", rd_addr0, 0);
    check("reset_out_data", out_data0, 0);
    rst = 1'b0;

    // Full dump, ready held high
    @(negedge clk);
    start0 = 1'b1;
    run0(0, 40);
    check("full_words", words, 16);
    check("full_order", order_err, 0);
    check("full_done_cnt", done_cnt, 1);
    check("full_done_cycle", done_cyc, 33);
    check("full_busy_after", busy_after, 0);
    check("full_first_valid", first_valid, 2);
    check("full_rden", rden_cnt, 16);

    // Backpressure
    @(negedge clk);
    start0 = 1'b1;
    run0(1, 110);
    check("bp_words", words, 16);
    check("bp_order", order_err, 0);
    check("bp_stable", stab_err, 0);
    check("bp_done_cnt", done_cnt, 1);
    check("bp_rden", rden_cnt, 16);

    // Start pulses while busy are ignored
    @(negedge clk);
    start0 = 1'b1;
    run0(2, 45);
    check("ign_words", words, 16);
    check("ign_rden", rden_cnt, 16);
    check("ign_done_cnt", done_cnt, 1);
    check("ign_done_cycle", done_cyc, 33);

    // Abort in SEND at address 7
    @(negedge clk);
    start0 = 1'b1;
    found = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      start0 = 1'b0;
      ready0 = 1'b1;
      if (valid0 && out_addr0 == 4'd7) begin
        found = 1;
        abort0 = 1'b1;
        ready0 = 1'b0;
        break;
      end
    end
    check("abort_reached_7", found, 1);
    @(negedge clk);
    abort0 = 1'b0;
    check("abort_valid", valid0, 0);
    check("abort_busy", busy0, 0);
    dcnt = 0;
    for (int c = 0; c < 5; c++) begin
      if (done0) dcnt++;
      @(negedge clk);
    end
    check("abort_no_done", dcnt, 0);

    // Restart after abort, then reset in the following READ cycle
    start0 = 1'b1;
    ready0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    @(negedge clk);
    check("restart_valid", valid0, 1);
    check("restart_addr", out_addr0, 0);
    check("restart_data", out_data0, 16'h1000);
    @(negedge clk);
    check("pre_rst_rd_en", rd_en0, 1);
    check("pre_rst_rd_addr", rd_addr0, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_rd_en", rd_en0, 0);
    check("rst_valid", valid0, 0);
    check("rst_rd_addr", rd_addr0, 0);
    check("rst_out_addr", out_addr0, 0);
    check("rst_out_data", out_data0, 0);

    // Sub-range instance 3..5
    start1 = 1'b1;
    n1 = 0; dcnt = 0; range_err = 0;
    for (int i = 0; i < 3; i++) begin
      a1[i] = '0;
      d1[i] = '0;
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      start1 = 1'b0;
      ready1 = 1'b1;
      if (rd_en1 && (rd_addr1 < 4'd3 || rd_addr1 > 4'd5)) range_err++;
      if (valid1) begin
        if (n1 < 3) begin
          a1[n1] = out_addr1;
          d1[n1] = out_data1;
        end
        n1++;
      end
      if (done1) dcnt++;
    end
    check("sub_words", n1, 3);
    check("sub_addr0", a1[0], 3);
    check("sub_addr1", a1[1], 4);
    check("sub_addr2", a1[2], 5);
    check("sub_data0", d1[0], 16'hAAAA);
    check("sub_data1", d1[1], 16'h5555);
    check("sub_data2", d1[2], 16'hBEEF);
    check("sub_done_cnt", dcnt, 1);
    check("sub_rd_range", range_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
